// File: rtl/apb_to_ahb.sv
// APB completer that forwards each access as a single AHB-Lite transfer.
// One transfer in flight at most; write strobes select the AHB size and byte offset.
module apb_to_ahb #(
    parameter int          ADDRWIDTH = 16,
    parameter logic [31:0] BASE_ADDR = 32'h4000_0000
) (
    input  logic                 HCLK,
    input  logic                 HRESETn,
    input  logic                 PSEL,
    input  logic                 PENABLE,
    input  logic                 PWRITE,
    input  logic [ADDRWIDTH-1:0] PADDR,
    input  logic [31:0]          PWDATA,
    input  logic [3:0]           PSTRB,
    input  logic [2:0]           PPROT,
    output logic [31:0]          PRDATA,
    output logic                 PREADY,
    output logic                 PSLVERR,
    output logic [31:0]          HADDR,
    output logic [1:0]           HTRANS,
    output logic                 HWRITE,
    output logic [2:0]           HSIZE,
    output logic [2:0]           HBURST,
    output logic [3:0]           HPROT,
    output logic                 HMASTLOCK,
    output logic [31:0]          HWDATA,
    input  logic [31:0]          HRDATA,
    input  logic                 HREADY,
    input  logic                 HRESP,
    output logic                 BUSY
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ADDR = 2'b01,
        ST_DATA = 2'b10,
        ST_RESP = 2'b11
    } state_t;

    // Returns {legal, hsize[2:0], lo2[1:0]} for a write strobe pattern.
    function automatic logic [5:0] decode_strb(input logic [3:0] strb);
        logic [5:0] res;
        case (strb)
            4'b1111: res = {1'b1, 3'b010, 2'b00};
            4'b0011: res = {1'b1, 3'b001, 2'b00};
            4'b1100: res = {1'b1, 3'b001, 2'b10};
            4'b0001: res = {1'b1, 3'b000, 2'b00};
            4'b0010: res = {1'b1, 3'b000, 2'b01};
            4'b0100: res = {1'b1, 3'b000, 2'b10};
            4'b1000: res = {1'b1, 3'b000, 2'b11};
            default: res = {1'b0, 3'b000, 2'b00};
        endcase
        return res;
    endfunction

    state_t      state_q, state_d;
    logic [31:0] haddr_q, haddr_d;
    logic        hwrite_q, hwrite_d;
    logic [2:0]  hsize_q, hsize_d;
    logic [3:0]  hprot_q, hprot_d;
    logic [31:0] hwdata_q, hwdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic        setup_s;
    logic [5:0]  strb_dec_s;
    logic        strb_ok_s;
    logic        unused_s;

    assign setup_s    = PSEL & ~PENABLE;
    assign strb_dec_s = decode_strb(PSTRB);
    assign strb_ok_s  = ~PWRITE | strb_dec_s[5];
    assign unused_s   = ^{PADDR[1:0], PPROT[1]};

    // State register.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; an illegal write strobe skips the AHB side entirely.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (setup_s) begin
                    state_d = strb_ok_s ? ST_ADDR : ST_RESP;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ADDR: state_d = HREADY ? ST_DATA : ST_ADDR;
            ST_DATA: state_d = HREADY ? ST_RESP : ST_DATA;
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Output decode from the registered state and captured transfer.
    always_comb begin
        HTRANS  = (state_q == ST_ADDR) ? 2'b10 : 2'b00;
        PREADY  = (state_q == ST_RESP);
        PSLVERR = (state_q == ST_RESP) & err_q;
        if ((state_q == ST_RESP) && !err_q && !hwrite_q) begin
            PRDATA = rdata_q;
        end else begin
            PRDATA = 32'h0000_0000;
        end
        BUSY = (state_q != ST_IDLE);
    end

    assign HADDR     = haddr_q;
    assign HWRITE    = hwrite_q;
    assign HSIZE     = hsize_q;
    assign HPROT     = hprot_q;
    assign HWDATA    = hwdata_q;
    assign HBURST    = 3'b000;
    assign HMASTLOCK = 1'b0;

    // Transfer capture at setup and response capture at the end of the data phase.
    always_comb begin
        haddr_d  = haddr_q;
        hwrite_d = hwrite_q;
        hsize_d  = hsize_q;
        hprot_d  = hprot_q;
        hwdata_d = hwdata_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        if ((state_q == ST_IDLE) && setup_s) begin
            hwrite_d = PWRITE;
            hprot_d  = {2'b00, PPROT[0], ~PPROT[2]};
            hwdata_d = PWDATA;
            err_d    = ~strb_ok_s;
            if (PWRITE) begin
                hsize_d = strb_dec_s[4:2];
                haddr_d = {BASE_ADDR[31:ADDRWIDTH], PADDR[ADDRWIDTH-1:2], strb_dec_s[1:0]};
            end else begin
                hsize_d = 3'b010;
                haddr_d = {BASE_ADDR[31:ADDRWIDTH], PADDR[ADDRWIDTH-1:2], 2'b00};
            end
        end else if ((state_q == ST_DATA) && HREADY) begin
            err_d = HRESP;
            if (!hwrite_q) begin
                rdata_d = HRDATA;
            end else begin
                rdata_d = rdata_q;
            end
        end else begin
            err_d = err_q;
        end
    end

    // Datapath registers.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            haddr_q  <= 32'h0000_0000;
            hwrite_q <= 1'b0;
            hsize_q  <= 3'b000;
            hprot_q  <= 4'b0000;
            hwdata_q <= 32'h0000_0000;
            rdata_q  <= 32'h0000_0000;
            err_q    <= 1'b0;
        end else begin
            haddr_q  <= haddr_d;
            hwrite_q <= hwrite_d;
            hsize_q  <= hsize_d;
            hprot_q  <= hprot_d;
            hwdata_q <= hwdata_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

endmodule

// File: tb/tb_apb_to_ahb.sv
// Directed bench for apb_to_ahb: hand-computed expectations for each access.
module tb_apb_to_ahb;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        PSEL, PENABLE, PWRITE;
    logic [15:0] PADDR;
    logic [31:0] PWDATA;
    logic [3:0]  PSTRB;
    logic [2:0]  PPROT;
    logic [31:0] PRDATA;
    logic        PREADY, PSLVERR;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE, HBURST;
    logic [3:0]  HPROT;
    logic        HMASTLOCK;
    logic [31:0] HWDATA, HRDATA;
    logic        HREADY, HRESP;
    logic        BUSY;

    int n_tot = 0;
    int n_bad = 0;

    always #5 HCLK = ~HCLK;

    apb_to_ahb #(.ADDRWIDTH(16), .BASE_ADDR(32'h4000_0000)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
        .PWDATA(PWDATA), .PSTRB(PSTRB), .PPROT(PPROT),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
        .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
        .HBURST(HBURST), .HPROT(HPROT), .HMASTLOCK(HMASTLOCK), .HWDATA(HWDATA),
        .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP), .BUSY(BUSY)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%08h exp=%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge HCLK);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".PREADY"},  {31'd0, PREADY},  32'd0);
        chk({tag, ".PSLVERR"}, {31'd0, PSLVERR}, 32'd0);
        chk({tag, ".PRDATA"},  PRDATA,           32'd0);
        chk({tag, ".HTRANS"},  {30'd0, HTRANS},  32'd0);
        chk({tag, ".HADDR"},   HADDR,            32'd0);
        chk({tag, ".HWRITE"},  {31'd0, HWRITE},  32'd0);
        chk({tag, ".HSIZE"},   {29'd0, HSIZE},   32'd0);
        chk({tag, ".HPROT"},   {28'd0, HPROT},   32'd0);
        chk({tag, ".HWDATA"},  HWDATA,           32'd0);
        chk({tag, ".BUSY"},    {31'd0, BUSY},    32'd0);
    endtask

    // One APB access with wa/wdw AHB wait cycles in the address/data phases.
    task automatic xfer(input string tg, input logic wr, input logic [15:0] a,
                        input logic [31:0] wd, input logic [3:0] st, input logic [2:0] pp,
                        input int wa, input int wdw, input logic [31:0] rd, input logic er,
                        input logic [31:0] eha, input logic [2:0] ehs, input logic [3:0] ehp,
                        input logic [31:0] eprd, input logic eerr);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = a;
        PWDATA = wd; PSTRB = st; PPROT = pp; HRESP = 1'b0; HREADY = 1'b1;
        step();
        PENABLE = 1'b1;
        for (int i = 0; i <= wa; i++) begin
            HREADY = (i == wa);
            chk({tg, ".htrans_a"}, {30'd0, HTRANS}, 32'h2);
            chk({tg, ".haddr"},    HADDR,           eha);
            chk({tg, ".hsize"},    {29'd0, HSIZE},  {29'd0, ehs});
            chk({tg, ".hwrite"},   {31'd0, HWRITE}, {31'd0, wr});
            chk({tg, ".hprot"},    {28'd0, HPROT},  {28'd0, ehp});
            chk({tg, ".pready_a"}, {31'd0, PREADY}, 32'd0);
            step();
        end
        for (int i = 0; i <= wdw; i++) begin
            HREADY = (i == wdw); HRDATA = rd; HRESP = er;
            chk({tg, ".htrans_d"}, {30'd0, HTRANS}, 32'h0);
            chk({tg, ".pready_d"}, {31'd0, PREADY}, 32'd0);
            if (wr) begin
                chk({tg, ".hwdata"}, HWDATA, wd);
            end
            step();
        end
        HREADY = 1'b1; HRESP = 1'b0;
        chk({tg, ".pready"},  {31'd0, PREADY},  32'd1);
        chk({tg, ".pslverr"}, {31'd0, PSLVERR}, {31'd0, eerr});
        chk({tg, ".prdata"},  PRDATA,           eprd);
        chk({tg, ".htrans_r"}, {30'd0, HTRANS}, 32'h0);
        PSEL = 1'b0; PENABLE = 1'b0;
        step();
        chk({tg, ".pready_after"}, {31'd0, PREADY}, 32'd0);
        chk({tg, ".prdata_after"}, PRDATA,          32'd0);
        chk({tg, ".busy_after"},   {31'd0, BUSY},   32'd0);
    endtask

    initial begin
        HRESETn = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        PADDR = 16'h0000; PWDATA = 32'h0; PSTRB = 4'h0; PPROT = 3'b000;
        HRDATA = 32'h0; HREADY = 1'b1; HRESP = 1'b0;
        #12;
        chk_reset_vals("reset");
        chk("hburst", {29'd0, HBURST}, 32'd0);
        chk("hmastlock", {31'd0, HMASTLOCK}, 32'd0);
        HRESETn = 1'b1;
        step();

        xfer("wword", 1'b1, 16'h0124, 32'hDEAD_BEEF, 4'b1111, 3'b010, 0, 0, 32'hFFFF_FFFF, 1'b0,
             32'h4000_0124, 3'b010, 4'b0001, 32'h0, 1'b0);
        xfer("wbyte", 1'b1, 16'h0010, 32'h1122_3344, 4'b0100, 3'b001, 0, 0, 32'hFFFF_FFFF, 1'b0,
             32'h4000_0012, 3'b000, 4'b0011, 32'h0, 1'b0);
        xfer("whalf", 1'b1, 16'h0010, 32'h5566_7788, 4'b1100, 3'b100, 0, 0, 32'hFFFF_FFFF, 1'b0,
             32'h4000_0012, 3'b001, 4'b0000, 32'h0, 1'b0);
        xfer("wb3", 1'b1, 16'h0013, 32'hAABB_CCDD, 4'b1000, 3'b000, 1, 0, 32'hFFFF_FFFF, 1'b0,
             32'h4000_0013, 3'b000, 4'b0001, 32'h0, 1'b0);
        xfer("rwait", 1'b0, 16'h0203, 32'h0, 4'b0101, 3'b101, 2, 3, 32'h1234_5678, 1'b0,
             32'h4000_0200, 3'b010, 4'b0010, 32'h1234_5678, 1'b0);

        // Illegal strobe: immediate error response, no AHB activity.
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 16'h0020;
        PWDATA = 32'h0; PSTRB = 4'b0101; PPROT = 3'b000;
        step();
        PENABLE = 1'b1;
        chk("ill.pready",  {31'd0, PREADY},  32'd1);
        chk("ill.pslverr", {31'd0, PSLVERR}, 32'd1);
        chk("ill.htrans",  {30'd0, HTRANS},  32'h0);
        chk("ill.prdata",  PRDATA,           32'd0);
        PSEL = 1'b0; PENABLE = 1'b0;
        step();
        chk("ill.htrans2", {30'd0, HTRANS},  32'h0);
        chk("ill.pready2", {31'd0, PREADY},  32'd0);
        chk("ill.pslverr2", {31'd0, PSLVERR}, 32'd0);

        xfer("rerr", 1'b0, 16'h0400, 32'h0, 4'b0000, 3'b000, 0, 1, 32'h9999_9999, 1'b1,
             32'h4000_0400, 3'b010, 4'b0001, 32'h0, 1'b1);

        // Reset asserted while the data phase is being stretched.
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 16'h0040;
        PWDATA = 32'hA5A5_A5A5; PSTRB = 4'b1111; PPROT = 3'b010; HREADY = 1'b1;
        step();
        PENABLE = 1'b1;
        step();
        HREADY = 1'b0;
        chk("rst.busy_pre",   {31'd0, BUSY}, 32'd1);
        chk("rst.hwdata_pre", HWDATA,        32'hA5A5_A5A5);
        #2;
        HRESETn = 1'b0;
        #1;
        chk_reset_vals("rstmid");
        step();
        HRESETn = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; HREADY = 1'b1;
        step();
        xfer("rpost", 1'b0, 16'h0300, 32'h0, 4'b0000, 3'b000, 0, 0, 32'hCAFE_F00D, 1'b0,
             32'h4000_0300, 3'b010, 4'b0001, 32'hCAFE_F00D, 1'b0);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule

// File: doc/apb_to_ahb.md
# apb_to_ahb

APB-to-AHB-Lite bridge. It is an APB completer on the peripheral side and a single-transfer AHB-Lite manager on the system side, so APB-attached logic can issue accesses into AHB address space. It is the reverse-direction companion to the existing AHB-to-APB bridge in the APB subsystem. APB and AHB share one clock.

## Interface
- ADDRWIDTH, 16: APB address width (≤ 31).
- BASE_ADDR, 32'h4000_0000: supplies HADDR[31:ADDRWIDTH]; lower bits of the parameter are ignored.
- HCLK in 1: single clock for both APB and AHB sides.
- HRESETn in 1: reset, asynchronous assert, active-low.
- PSEL, PENABLE, PWRITE in 1 each: APB control.
- PADDR in ADDRWIDTH: APB address; bits [1:0] are ignored.
- PWDATA in 32: APB write data.
- PSTRB in 4: APB write strobes.
- PPROT in 3: APB protection.
- PRDATA out 32: APB read data.
- PREADY out 1: APB ready.
- PSLVERR out 1: APB error.
- HADDR out 32, HTRANS out 2, HWRITE out 1, HSIZE out 3: AHB address and control.
- HBURST out 3: constant 3'b000 (SINGLE).
- HPROT out 4: AHB protection.
- HMASTLOCK out 1: constant 0.
- HWDATA out 32: AHB write data.
- HRDATA in 32, HREADY in 1, HRESP in 1: AHB response.
- BUSY out 1: high in any state other than IDLE.

## Operation
- FSM has four states: IDLE, ADDR, DATA, RESP.
- IDLE: on the APB setup phase (PSEL=1, PENABLE=0), capture PADDR, PWRITE, PWDATA, PSTRB and PPROT.
  - Write with an illegal strobe: set err=1 and go to RESP. No AHB transfer is issued.
  - Otherwise: go to ADDR.
- Legal write strobes, with resulting HSIZE and HADDR[1:0]:
  - 1111: word, 00.
  - 0011: halfword, 00.
  - 1100: halfword, 10.
  - 0001 / 0010 / 0100 / 1000: byte, 00 / 01 / 10 / 11.
  - Every other pattern is illegal, including 0000 on a write.
- Reads ignore PSTRB and always use word size with HADDR[1:0]=00.
- HADDR = {BASE_ADDR[31:ADDRWIDTH], addr_q[ADDRWIDTH-1:2], lo2}.
- HPROT = {2'b00, PPROT[0], ~PPROT[2]}.
- ADDR: HTRANS=NONSEQ (2'b10), with HADDR/HWRITE/HSIZE/HPROT driven from registers. Hold until HREADY=1, then go to DATA.
- DATA: HTRANS=IDLE; HWDATA = captured PWDATA (all 32 bits, lanes unchanged). Hold until HREADY=1, then:
  - capture HRDATA into rdata_q (reads only);
  - set err = HRESP;
  - go to RESP.
- AHB ERROR response is two cycles. The first cycle (HRESP=1, HREADY=0) is waited through; the value is sampled on the HREADY=1 cycle. No further AHB transfer follows, so no cancellation is needed.
- RESP: PREADY=1 and PSLVERR=err.
  - PRDATA = rdata_q on a read with err=0; otherwise 0.
  - Next state is IDLE unconditionally.
  - A new setup phase is not accepted in RESP; it is accepted in the IDLE cycle that follows.
- PSEL dropping mid-transfer (protocol violation): the AHB transfer completes normally, RESP still pulses, and the result is discarded.
- Outputs outside RESP: PREADY=0, PSLVERR=0, PRDATA=0.
- Outputs outside ADDR: HTRANS=IDLE.

## Timing
- Reset values: state=IDLE, PREADY=0, PSLVERR=0, PRDATA=0, HTRANS=2'b00, HADDR=0, HWRITE=0, HSIZE=3'b000, HPROT=0, HWDATA=0, rdata_q=0, err=0, BUSY=0.
- Reset asserted mid-transfer: all outputs take reset values immediately (asynchronous). Any AHB transfer in flight is abandoned.
- Zero-wait AHB, access setup at cycle T0:
  - T1: ADDR (NONSEQ on bus).
  - T2: DATA.
  - T3: RESP (PREADY=1).
  - Result: two APB wait states, 4 cycles total from setup.
- Each AHB wait cycle, in either ADDR or DATA, adds one cycle.
- Illegal strobe: PREADY=1 at T1 with PSLVERR=1 (zero APB wait states). HTRANS never leaves IDLE.
- Back-to-back APB transfers: a new setup one cycle after RESP gives HTRANS=NONSEQ one cycle after that setup.
- At most one AHB transfer is ever outstanding. HTRANS=NONSEQ is never asserted in two consecutive cycles unless HREADY=0 is holding the address phase.

## Test plan
- Word write: PADDR=16'h0124, PWDATA=32'hDEADBEEF, PSTRB=1111, zero-wait AHB.
  - Expect HADDR=32'h4000_0124, HSIZE=010, HWRITE=1, HWDATA=DEADBEEF in DATA.
  - Expect PREADY at T3, PSLVERR=0.
- Byte and halfword writes at PADDR=16'h0010:
  - PSTRB=0100 → HADDR=32'h4000_0012, HSIZE=000.
  - PSTRB=1100 → HADDR=32'h4000_0012, HSIZE=001.
- Read with wait states: HRDATA=32'h1234_5678, HREADY held low 2 cycles in ADDR and 3 cycles in DATA.
  - Expect PREADY at T8 with PRDATA=32'h1234_5678.
  - Expect PRDATA=0 in the cycle after.
- Illegal strobe PSTRB=0101 on a write.
  - Expect PREADY=PSLVERR=1 at T1, HTRANS=00 throughout.
- AHB ERROR on a read: HRESP=1/HREADY=0, then HRESP=1/HREADY=1.
  - Expect PSLVERR=1 and PRDATA=0 at RESP.
- Reset mid-DATA with HREADY=0.
  - Expect all outputs at reset values the same cycle.
  - After release, a new word read completes normally.
